// File: rtl/victim_wb_buffer_pkg.sv
// Shared types and helpers for the victim/write-back buffer.
// Drain FSM states and the slot-index width helper.
package victim_wb_buffer_pkg;

  typedef enum logic [1:0] {
    VWB_IDLE,
    VWB_WRITE,
    VWB_FLUSH
  } vwb_state_t;

  function automatic int vwb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/victim_wb_buffer_age_tracker.sv
// Insertion-age tracker: valid slots hold a permutation 0..n-1 (0 = newest);
// reports the oldest dirty and oldest clean valid slots.
module vwb_age_tracker
  import victim_wb_buffer_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = vwb_idx_w(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [ENTRIES-1:0] dirty_i,
  input  logic               ins_i,
  input  logic               ins_new_i,
  input  logic [IDX_W-1:0]   ins_idx_i,
  input  logic               take_i,
  input  logic [IDX_W-1:0]   take_idx_i,
  output logic [IDX_W-1:0]   oldest_dirty_o,
  output logic               any_dirty_o,
  output logic [IDX_W-1:0]   oldest_clean_o,
  output logic               any_clean_o
);

  logic [IDX_W-1:0] age [ENTRIES];
  logic [IDX_W-1:0] ins_age;
  logic [IDX_W-1:0] take_age;

  assign ins_age  = age[ins_idx_i];
  assign take_age = age[take_idx_i];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_age
    logic [IDX_W-1:0] age_q;
    logic [IDX_W-1:0] age_d;
    logic             inc;
    logic             dec;

    assign age[gi] = age_q;
    // A brand-new slot pushes every valid entry back; a reused one only the younger ones.
    assign inc = ins_i && valid_i[gi] && (ins_new_i || (age_q < ins_age));
    assign dec = take_i && valid_i[gi] && (age_q > take_age);

    always_comb begin
      age_d = age_q;
      if ((ins_i && (ins_idx_i == IDX_W'(gi))) || (take_i && (take_idx_i == IDX_W'(gi))))
        age_d = '0;
      else if (valid_i[gi])
        age_d = age_q + IDX_W'(inc) - IDX_W'(dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) age_q <= '0;
      else        age_q <= age_d;
    end
  end

  logic [IDX_W-1:0] dsel;
  logic [IDX_W-1:0] csel;
  logic             dfound;
  logic             cfound;

  always_comb begin
    dsel   = '0;
    csel   = '0;
    dfound = 1'b0;
    cfound = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_i[i] && dirty_i[i] && (!dfound || (age[i] > age[dsel]))) begin
        dfound = 1'b1;
        dsel   = IDX_W'(i);
      end
      if (valid_i[i] && !dirty_i[i] && (!cfound || (age[i] > age[csel]))) begin
        cfound = 1'b1;
        csel   = IDX_W'(i);
      end
    end
  end

  assign oldest_dirty_o = dsel;
  assign any_dirty_o    = dfound;
  assign oldest_clean_o = csel;
  assign any_clean_o    = cfound;

endmodule

// File: rtl/victim_wb_buffer.sv
// Fully-associative victim/write-back buffer with background drain to pmem.
// Optional flush mode is enabled by defining VWB_FLUSH_EN.
module victim_wb_buffer
  import victim_wb_buffer_pkg::*;
#(
  parameter int ENTRIES  = 4,
  parameter int TAG_W    = 12,
  parameter int OFFSET_W = 4,
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [LINE_W-1:0] hit_data,
  input  logic              take,
  input  logic              evict_valid,
  output logic              evict_ready,
  input  logic              evict_dirty,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [LINE_W-1:0] evict_data,
  input  logic              drain_en,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic              flush,
  output logic              flush_done
);

  localparam int IDX_W = vwb_idx_w(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [LINE_W-1:0]  data_q [ENTRIES];

  logic [TAG_W-1:0]   lookup_tag, evict_tag;
  logic [ENTRIES-1:0] look_match, evict_match;
  logic [IDX_W-1:0]   hit_idx, present_idx, free_idx, ins_idx;
  logic               any_free, ins_present, ins_fire, take_fire, flushing;
  logic [IDX_W-1:0]   oldest_dirty, oldest_clean;
  logic               any_dirty, any_clean;
  logic [2*OFFSET_W-1:0] offset_unused;

  assign lookup_tag    = lookup_addr[ADDR_W-1:OFFSET_W];
  assign evict_tag     = evict_addr[ADDR_W-1:OFFSET_W];
  assign offset_unused = {lookup_addr[OFFSET_W-1:0], evict_addr[OFFSET_W-1:0]};

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
    assign look_match[gi]  = valid_q[gi] && (tag_q[gi] == lookup_tag);
    assign evict_match[gi] = valid_q[gi] && (tag_q[gi] == evict_tag);
  end

  always_comb begin
    hit_idx     = '0;
    hit_data    = '0;
    present_idx = '0;
    free_idx    = '0;
    any_free    = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (look_match[i]) begin
        hit_idx  = IDX_W'(i);
        hit_data = data_q[i];
      end
      if (evict_match[i]) present_idx = IDX_W'(i);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign hit         = |look_match;
  assign ins_present = |evict_match;
  assign ins_idx     = ins_present ? present_idx : (any_free ? free_idx : oldest_clean);
  assign evict_ready = !flushing && (ins_present || any_free || any_clean);
  assign ins_fire    = evict_valid && evict_ready;
  // When insert and take land on the same slot, the insert wins.
  assign take_fire   = take && hit && !(ins_fire && (ins_idx == hit_idx));

  vwb_age_tracker #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_age (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (valid_q),
    .dirty_i        (dirty_q),
    .ins_i          (ins_fire),
    .ins_new_i      (!ins_present && any_free),
    .ins_idx_i      (ins_idx),
    .take_i         (take_fire),
    .take_idx_i     (hit_idx),
    .oldest_dirty_o (oldest_dirty),
    .any_dirty_o    (any_dirty),
    .oldest_clean_o (oldest_clean),
    .any_clean_o    (any_clean)
  );

  // Drain engine state
  vwb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  d_q, d_d;
  logic              live_q, live_d;
  logic              redirty_q, redirty_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic              latch, complete, drain_clear;
`ifdef VWB_FLUSH_EN
  logic              flush_act_q, flush_act_d;
  logic              flush_done_q, flush_done_d;
`endif

  always_comb begin
    state_d        = state_q;
    d_d            = d_q;
    live_d         = live_q;
    redirty_d      = redirty_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    latch          = 1'b0;
    complete       = 1'b0;
`ifdef VWB_FLUSH_EN
    flush_act_d    = flush_act_q;
    flush_done_d   = 1'b0;
`endif
    case (state_q)
      VWB_IDLE: begin
`ifdef VWB_FLUSH_EN
        if (flush) begin
          state_d     = VWB_FLUSH;
          flush_act_d = 1'b1;
        end else if (drain_en && any_dirty) begin
          latch = 1'b1;
        end
`else
        if (drain_en && any_dirty) latch = 1'b1;
`endif
      end
`ifdef VWB_FLUSH_EN
      VWB_FLUSH: begin
        if (any_dirty) begin
          latch = 1'b1;
        end else begin
          state_d      = VWB_IDLE;
          flush_act_d  = 1'b0;
          flush_done_d = 1'b1;
        end
      end
`endif
      VWB_WRITE: begin
        if (take_fire && (hit_idx == d_q)) live_d = 1'b0;
        if (ins_fire && ins_present && (ins_idx == d_q) && evict_dirty) redirty_d = 1'b1;
        if (pmem_resp) begin
          complete     = 1'b1;
          pmem_write_d = 1'b0;
`ifdef VWB_FLUSH_EN
          state_d      = flush_act_q ? VWB_FLUSH : VWB_IDLE;
`else
          state_d      = VWB_IDLE;
`endif
        end
      end
      default: state_d = VWB_IDLE;
    endcase
    // The snapshot is taken from pre-edge contents; a same-edge dirty overwrite must re-dirty.
    if (latch) begin
      state_d        = VWB_WRITE;
      d_d            = oldest_dirty;
      live_d         = !(take_fire && (hit_idx == oldest_dirty));
      redirty_d      = ins_fire && ins_present && (ins_idx == oldest_dirty) && evict_dirty;
      pmem_write_d   = 1'b1;
      pmem_address_d = {tag_q[oldest_dirty], {OFFSET_W{1'b0}}};
      pmem_wdata_d   = data_q[oldest_dirty];
    end
  end

  assign drain_clear = complete && live_q && !redirty_q;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (drain_clear) dirty_d[d_q] = 1'b0;
    if (take_fire) begin
      valid_d[hit_idx] = 1'b0;
      dirty_d[hit_idx] = 1'b0;
    end
    if (ins_fire) begin
      valid_d[ins_idx] = 1'b1;
      dirty_d[ins_idx] = (ins_present && dirty_d[ins_idx]) || evict_dirty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      dirty_q        <= '0;
      state_q        <= VWB_IDLE;
      d_q            <= '0;
      live_q         <= 1'b0;
      redirty_q      <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      state_q        <= state_d;
      d_q            <= d_d;
      live_q         <= live_d;
      redirty_q      <= redirty_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ins_fire) begin
      tag_q[ins_idx]  <= evict_tag;
      data_q[ins_idx] <= evict_data;
    end
  end

`ifdef VWB_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_act_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      flush_act_q  <= flush_act_d;
      flush_done_q <= flush_done_d;
    end
  end
  assign flushing   = flush_act_q;
  assign flush_done = flush_done_q;
`else
  logic flush_unused;
  assign flush_unused = flush;
  assign flushing     = 1'b0;
  assign flush_done   = 1'b0;
`endif

  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Randomized bench for victim_wb_buffer against an insertion-ordered list model.
// Flush stimulus is added when VWB_FLUSH_EN is defined.
module tb_victim_wb_buffer;

  localparam int ENTRIES  = 4;
  localparam int TAG_W    = 12;
  localparam int OFFSET_W = 4;
  localparam int ADDR_W   = 16;
  localparam int LINE_W   = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] lookup_addr = '0;
  logic              hit;
  logic [LINE_W-1:0] hit_data;
  logic              take = 1'b0;
  logic              evict_valid = 1'b0;
  logic              evict_ready;
  logic              evict_dirty = 1'b0;
  logic [ADDR_W-1:0] evict_addr = '0;
  logic [LINE_W-1:0] evict_data = '0;
  logic              drain_en = 1'b0;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp = 1'b0;
  logic              flush = 1'b0;
  logic              flush_done;

  always #5 clk = ~clk;

  victim_wb_buffer #(
    .ENTRIES(ENTRIES), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W), .ADDR_W(ADDR_W), .LINE_W(LINE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lookup_addr(lookup_addr), .hit(hit), .hit_data(hit_data),
    .take(take), .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_dirty(evict_dirty),
    .evict_addr(evict_addr), .evict_data(evict_data), .drain_en(drain_en),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .flush(flush), .flush_done(flush_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: slot contents plus a list of slots ordered newest-first.
  bit                m_valid [ENTRIES];
  bit                m_dirty [ENTRIES];
  logic [TAG_W-1:0]  m_tag   [ENTRIES];
  logic [LINE_W-1:0] m_data  [ENTRIES];
  int                m_order [$];
  bit                m_busy, m_live, m_redirty, m_flush, m_flush_done;
  int                m_d;
  logic [ADDR_W-1:0] m_paddr;
  logic [LINE_W-1:0] m_pdata;

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_order.delete();
    m_busy = 0; m_live = 0; m_redirty = 0; m_flush = 0; m_flush_done = 0;
  endfunction

  function automatic int m_find(input logic [TAG_W-1:0] t);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < ENTRIES; i++)
      if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int m_oldest(input bit want_dirty);
    for (int p = m_order.size() - 1; p >= 0; p--)
      if (m_dirty[m_order[p]] == want_dirty) return m_order[p];
    return -1;
  endfunction

  function automatic void m_remove(input int k);
    for (int p = 0; p < m_order.size(); p++)
      if (m_order[p] == k) begin
        m_order.delete(p);
        return;
      end
  endfunction

  function automatic bit m_ready();
    return !m_flush && (m_find(evict_addr[ADDR_W-1:OFFSET_W]) >= 0 || m_free() >= 0 || m_oldest(0) >= 0);
  endfunction

  function automatic logic [ADDR_W-1:0] rnd_addr();
    logic [TAG_W-1:0] t;
    case ($urandom_range(0, 5))
      0: t = 12'h100;
      1: t = 12'h200;
      2: t = 12'h300;
      3: t = 12'h400;
      4: t = 12'h123;
      default: t = 12'h555;
    endcase
    return {t, 4'($urandom)};
  endfunction

  task automatic check_outputs();
    int h;
    logic [LINE_W-1:0] exp_data;
    h = m_find(lookup_addr[ADDR_W-1:OFFSET_W]);
    exp_data = '0;
    if (h >= 0) exp_data = m_data[h];
    check_eq("hit", LINE_W'(hit), LINE_W'(h >= 0));
    check_eq("hit_data", hit_data, exp_data);
    check_eq("evict_ready", LINE_W'(evict_ready), LINE_W'(m_ready()));
    check_eq("pmem_write", LINE_W'(pmem_write), LINE_W'(m_busy));
    if (m_busy) begin
      check_eq("pmem_address", LINE_W'(pmem_address), LINE_W'(m_paddr));
      check_eq("pmem_wdata", pmem_wdata, m_pdata);
    end
    check_eq("flush_done", LINE_W'(flush_done), LINE_W'(m_flush_done));
  endtask

  // Advance the model across one clock edge using the current (pre-edge) inputs.
  task automatic model_step();
    logic [TAG_W-1:0] et;
    int  h, p, k, dsel;
    bit  ins, tk, go, fdone;
    et   = evict_addr[ADDR_W-1:OFFSET_W];
    h    = m_find(lookup_addr[ADDR_W-1:OFFSET_W]);
    p    = m_find(et);
    ins  = evict_valid && m_ready();
    k    = (p >= 0) ? p : ((m_free() >= 0) ? m_free() : m_oldest(0));
    tk   = take && (h >= 0) && !(ins && k == h);
    dsel = m_oldest(1);
    fdone = 0;
    go    = 0;
    if (m_busy) begin
      if (pmem_resp) begin
        if (m_live && !m_redirty) m_dirty[m_d] = 0;
        m_busy = 0;
        $display("pmem write done addr=%h live=%0d redirty=%0d", m_paddr, m_live, m_redirty);
      end else begin
        if (tk && h == m_d) m_live = 0;
        if (ins && p >= 0 && k == m_d && evict_dirty) m_redirty = 1;
      end
    end else begin
`ifdef VWB_FLUSH_EN
      if (m_flush) begin
        if (dsel >= 0) go = 1;
        else begin
          m_flush = 0;
          fdone   = 1;
        end
      end else if (flush) m_flush = 1;
      else
`endif
      go = drain_en && (dsel >= 0);
      if (go) begin
        m_busy    = 1;
        m_d       = dsel;
        m_paddr   = {m_tag[dsel], {OFFSET_W{1'b0}}};
        m_pdata   = m_data[dsel];
        m_live    = !(tk && h == dsel);
        m_redirty = ins && p >= 0 && k == dsel && evict_dirty;
      end
    end
    m_flush_done = fdone;
    if (tk) begin
      m_valid[h] = 0;
      m_dirty[h] = 0;
      m_remove(h);
      $display("take slot=%0d tag=%h", h, m_tag[h]);
    end
    if (ins) begin
      m_dirty[k] = (p >= 0 && m_dirty[k]) || evict_dirty;
      m_valid[k] = 1;
      m_tag[k]   = et;
      m_data[k]  = evict_data;
      m_remove(k);
      m_order.push_front(k);
      $display("insert slot=%0d tag=%h dirty=%0d reuse=%0d", k, et, evict_dirty, p >= 0);
    end
  endtask

  int ph_len   [4] = '{80, 600, 600, 600};
  int ev_pct   [4] = '{70, 40, 50, 60};
  int dirt_pct [4] = '{100, 60, 40, 20};
  int take_pct [4] = '{0, 10, 50, 10};
  int drn_pct  [4] = '{0, 60, 50, 30};
  int resp_pct [4] = '{50, 40, 30, 50};

  task automatic drive_inputs(input int ph);
    lookup_addr = rnd_addr();
    take        = ($urandom_range(0, 99) < take_pct[ph]);
    evict_valid = ($urandom_range(0, 99) < ev_pct[ph]);
    evict_dirty = ($urandom_range(0, 99) < dirt_pct[ph]);
    evict_addr  = rnd_addr();
    evict_data  = {$urandom, $urandom, $urandom, $urandom};
    drain_en    = ($urandom_range(0, 99) < drn_pct[ph]);
    pmem_resp   = ($urandom_range(0, 99) < resp_pct[ph]);
`ifdef VWB_FLUSH_EN
    flush       = (ph >= 2) && ($urandom_range(0, 99) < 4);
`else
    flush       = 1'b0;
`endif
  endtask

  task automatic check_reset_state(input string where);
    check_eq({where, "_hit"}, LINE_W'(hit), '0);
    check_eq({where, "_hit_data"}, hit_data, '0);
    check_eq({where, "_evict_ready"}, LINE_W'(evict_ready), LINE_W'(1));
    check_eq({where, "_pmem_write"}, LINE_W'(pmem_write), '0);
    check_eq({where, "_pmem_address"}, LINE_W'(pmem_address), '0);
    check_eq({where, "_pmem_wdata"}, pmem_wdata, '0);
    check_eq({where, "_flush_done"}, LINE_W'(flush_done), '0);
  endtask

  initial begin
    bit rst_done;
    rst_done = 0;
    m_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("reset");
    $display("reset released");
    rst_n = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      for (int cyc = 0; cyc < ph_len[ph]; cyc++) begin
        @(negedge clk);
        if (ph == 1 && cyc >= 200 && m_busy && !rst_done) begin
          rst_done = 1;
          rst_n = 1'b0;
          #1;
          check_reset_state("midrst");
          m_reset();
          $display("async reset during drain");
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          continue;
        end
        drive_inputs(ph);
        #1;
        check_outputs();
        model_step();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/victim_wb_buffer.md
Name: victim_wb_buffer

Overview:
Parametrised fully-associative victim/write-back buffer that sits between the L1 cache and physical memory. It accepts evicted lines, serves hits back to the cache, and drains dirty lines to pmem through its own request/response FSM. It replaces the fixed 4-way, stateless eviction store with configurable depth and widths, per-entry dirty tracking, true insertion-age ordering and a background drain engine.

Parameters:
ENTRIES, 4, number of line slots (power of two, 2..16)
TAG_W, 12, tag width = ADDR_W - OFFSET_W
OFFSET_W, 4, line offset bits
ADDR_W, 16, address width
LINE_W, 128, line data width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lookup_addr  in  ADDR_W  cache miss address; tag = lookup_addr[ADDR_W-1:OFFSET_W]
hit  out  1  combinational: valid entry tag matches
hit_data  out  LINE_W  data of matching entry (0 when !hit)
take  in  1  with hit: invalidate matching entry at clock edge
evict_valid  in  1  cache offers an evicted line
evict_ready  out  1  buffer can accept this cycle
evict_dirty  in  1  offered line needs write-back
evict_addr  in  ADDR_W  line address of victim
evict_data  in  LINE_W  victim data
drain_en  in  1  pmem bus available for a new drain
pmem_write  out  1  write request, held until pmem_resp
pmem_address  out  ADDR_W  {tag, OFFSET_W'b0} of entry being drained
pmem_wdata  out  LINE_W  data of entry being drained
pmem_resp  in  1  write complete
flush  in  1  (macro only) drain all dirty entries
flush_done  out  1  (macro only) one-cycle pulse

Behaviour:
- Reset (async, rst_n=0): all valid/dirty=0, ages=0, FSM IDLE, pmem_write=0, pmem_address=0, pmem_wdata=0, hit=0, hit_data=0, evict_ready=1, flush_done=0. Reset mid-drain abandons the request; pmem_write drops immediately.
- Lookup: purely combinational, zero latency. At most one match (insert enforces uniqueness). take without hit is ignored.
- Age: valid entries hold a permutation 0..n-1 (0 = newest). Insert into slot k: valid entries younger than k's old age (all valid entries if k is new) +1; age[k]=0. Take of k: entries older than k -1.
- Insert on evict_valid&evict_ready:
  - Tag already present: overwrite data in place, dirty |= evict_dirty, age -> 0.
  - Otherwise allocate the lowest-index invalid slot; if none, replace the oldest clean entry.
- evict_ready=0 only when every slot is valid and dirty and the tag is not already present.
- Drain FSM IDLE -> WRITE -> IDLE:
  - IDLE: if drain_en and any dirty entry, latch slot index D = oldest dirty. Drive pmem_address/pmem_wdata from D the next cycle with pmem_write=1.
  - WRITE: hold outputs stable from the latched snapshot; on pmem_resp clear dirty[D] (entry stays valid, clean) and return to IDLE. Next drain starts at the earliest one cycle later.
- Simultaneous events:
  - Take of D during WRITE: entry freed immediately; drain completes, completion is a no-op.
  - Overwrite of D with dirty data during WRITE: set redirty flag, so completion leaves dirty=1.
  - Insert and take of different slots in the same cycle: both apply.
  - Insert and take of the same tag: insert wins.
  - Insert into a slot freed by take that cycle: not allowed; allocation uses pre-edge state.
- Widths: age counters are $clog2(ENTRIES) bits. No overflow is possible.

Optional Feature:
VWB_FLUSH_EN.
- Defined: flush=1 in IDLE enters FLUSH mode. Drain ignores drain_en and repeats until no dirty entry remains, then pulses flush_done for one cycle and returns to normal. evict_ready=0 while flushing. Lookups and takes continue.
- Undefined: flush is ignored, flush_done is tied 0, and the FSM has no FLUSH state.

Decomposition:
- Add to lc3b_types: vwb_state_t enum {VWB_IDLE, VWB_WRITE, VWB_FLUSH}, and a parametrised slot-index width helper.
- One sub-module, vwb_age_tracker: owns the age permutation and outputs oldest_dirty and oldest_clean indices.
- Tag/data storage stays inline as per-slot registers.

Test Plan:
- Reset, insert clean 0x1230 then lookup 0x1234 -> hit=1, hit_data = inserted data. take -> next cycle hit=0.
- Insert dirty 0x1000, 0x2000, 0x3000, 0x4000 (ENTRIES=4), drain_en=0 -> evict_ready=0. Fifth offer stalls until drain_en=1 and pmem_resp; first write address is 0x1000.
- Drain of 0x2000 in WRITE, then re-insert dirty 0x2000 with new data -> after pmem_resp, dirty remains; a second drain writes the new data.
- take of the entry in WRITE -> pmem_write held until pmem_resp, slot invalid, no further write for that tag.
- All slots valid, two clean (ages 1 and 3) -> new insert replaces the age-3 slot; the age-1 line still hits.
- VWB_FLUSH_EN, 3 dirty entries, drain_en=0, flush=1 -> three pmem writes oldest-first, flush_done pulses once, and no dirty entries remain.
